// File: rtl/ooo_pkg.sv
// Shared front-end types: the {pc, instr} pair carried from fetch to decode.
package ooo_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] INSTR_NOP_ZERO = 32'h0;

endpackage

// File: rtl/fifo_ram.sv
// Unreset storage array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode decoupling FIFO with early stall, zero-word drop and one-cycle flush.
module instr_fetch_queue
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SKID      = 2,
  parameter int unsigned DROP_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid_i,
  input  logic [XLEN-1:0]            fetch_pc_i,
  input  logic [XLEN-1:0]            fetch_instr_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic                       dec_valid_o,
  output logic [XLEN-1:0]            dec_pc_o,
  output logic [XLEN-1:0]            dec_instr_o,
  input  logic                       dec_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_drop_zero;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_rd_entry;

  // Full/empty come only from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_drop_zero = (DROP_ZERO != 0) && (fetch_instr_i == INSTR_NOP_ZERO);
  assign w_push_req  = fetch_valid_i && !w_drop_zero && !flush_i;
  assign w_push      = w_push_req && !w_full;
  assign w_pop       = !w_empty && dec_ready_i && !flush_i;

  assign w_wr_entry.pc    = fetch_pc_i;
  assign w_wr_entry.instr = fetch_instr_i;

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      // Redirect: drop everything but keep the sticky overflow record.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign dec_valid_o = !w_empty;
  assign dec_pc_o    = w_empty ? '0 : w_rd_entry.pc;
  assign dec_instr_o = w_empty ? '0 : w_rd_entry.instr;
  assign stall_o     = (r_count >= CW'(DEPTH - SKID));
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= CW'(DEPTH))
        else $error("instr_fetch_queue: count %0d exceeds depth", r_count);
      assert (!(w_pop && w_empty))
        else $error("instr_fetch_queue: pop from empty queue");
      assert (!(w_push && w_full))
        else $error("instr_fetch_queue: push into full queue");
    end
  end
`endif

endmodule
